// File: rtl/b_resp_order_queue_pkg.sv
// ----------------------------------------------------------------------------
// b_resp_order_queue_pkg
// Shared write-path definitions: AXI BRESP response codes and the default
// master ID width used by the write-response ordering logic.
// ----------------------------------------------------------------------------
package b_resp_order_queue_pkg;

    // AXI write response codes carried on the B channel.
    typedef enum logic [1:0] {
        BRESP_OKAY   = 2'd0,
        BRESP_EXOKAY = 2'd1,
        BRESP_SLVERR = 2'd2,
        BRESP_DECERR = 2'd3
    } bresp_e;

    // One bit distinguishes the two masters M00/M01.
    localparam int DEFAULT_MID_W = 1;

endpackage : b_resp_order_queue_pkg

// File: rtl/b_resp_order_queue_id_fifo.sv
// ----------------------------------------------------------------------------
// b_resp_order_queue_id_fifo
// Parameterised synchronous FIFO that holds the master IDs of completed write
// bursts in completion order.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   push       in   write push_data at the tail (ignored when full)
//   push_data  in   W-bit entry
//   pop        in   drop the head entry (ignored when empty)
//   head       out  oldest entry (registered storage, no write bypass)
//   count      out  number of stored entries, 0..DEPTH
//   full       out  count == DEPTH
//   empty      out  count == 0
// ----------------------------------------------------------------------------
module b_resp_order_queue_id_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count_nxt;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; an entry is only ever read
    // after it has been written, and the pointers/count carry the real state.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: default assignment first keeps this always_comb free of latches.
    always_comb begin
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
        end
    end

endmodule : b_resp_order_queue_id_fifo

// File: rtl/b_resp_order_queue.sv
// ----------------------------------------------------------------------------
// b_resp_order_queue
// Releases slave write responses in the order their write-data bursts
// completed. Each completed W burst pushes its master ID; a slave B response
// is accepted only when its ID matches the oldest outstanding burst, and is
// then presented through a registered output stage. Mismatched responses stall
// (never drop) and raise a sticky error after TIMEOUT cycles; responses that
// arrive with nothing outstanding pulse unexp_err.
//
// Ports:
//   ACLK        in   clock, rising edge
//   ARESET      in   synchronous active-high reset
//   push_valid  in   W burst completed this cycle
//   push_mid    in   master ID of that burst
//   push_ready  out  queue not full
//   sb_valid    in   slave B response valid
//   sb_id       in   slave B response ID
//   sb_resp     in   slave B response code
//   sb_ready    out  slave response accepted (combinational)
//   ob_valid    out  ordered response valid (registered)
//   ob_id       out  master ID of ordered response
//   ob_resp     out  response code of ordered response
//   ob_ready    in   downstream B controller accepts
//   occupancy   out  outstanding entries
//   order_err   out  sticky: mismatch stalled for TIMEOUT cycles
//   unexp_err   out  registered pulse: sb_valid seen while queue empty
// ----------------------------------------------------------------------------
module b_resp_order_queue
    import b_resp_order_queue_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int MID_W   = DEFAULT_MID_W,
    parameter int TIMEOUT = 64
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic                     push_valid,
    input  logic [MID_W-1:0]         push_mid,
    output logic                     push_ready,
    input  logic                     sb_valid,
    input  logic [MID_W-1:0]         sb_id,
    input  logic [1:0]               sb_resp,
    output logic                     sb_ready,
    output logic                     ob_valid,
    output logic [MID_W-1:0]         ob_id,
    output logic [1:0]               ob_resp,
    input  logic                     ob_ready,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     order_err,
    output logic                     unexp_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    logic [MID_W-1:0] head;
    logic             full;
    logic             empty;
    logic             head_match;
    logic             out_free;
    logic             accept;
    logic             mismatch;
    logic [CNT_W-1:0] stall_cnt;

    b_resp_order_queue_id_fifo #(
        .DEPTH (DEPTH),
        .W     (MID_W)
    ) u_id_fifo (
        .clk       (ACLK),
        .rst       (ARESET),
        .push      (push_valid && push_ready),
        .push_data (push_mid),
        .pop       (accept),
        .head      (head),
        .count     (occupancy),
        .full      (full),
        .empty     (empty)
    );

    // Full refuses a push even if a pop happens in the same cycle.
    assign push_ready = !full;

    // The output stage can take a new response when it is empty or draining.
    assign head_match = (sb_id == head);
    assign out_free   = !ob_valid || ob_ready;
    assign sb_ready   = !empty && head_match && out_free;
    assign accept     = sb_valid && sb_ready;
    assign mismatch   = sb_valid && !empty && !head_match;

    // Output register: an accept reloads it (back-to-back throughput);
    // otherwise it empties on handshake and holds while stalled downstream.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            ob_valid <= 1'b0;
            ob_id    <= '0;
            ob_resp  <= BRESP_OKAY;
        end else if (accept) begin
            ob_valid <= 1'b1;
            ob_id    <= sb_id;
            ob_resp  <= sb_resp;
        end else if (ob_ready) begin
            ob_valid <= 1'b0;
        end
    end

    // Stall tracking: counts consecutive mismatch cycles, saturating at
    // TIMEOUT. order_err sets on the edge the count reaches TIMEOUT.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            stall_cnt <= '0;
            order_err <= 1'b0;
            unexp_err <= 1'b0;
        end else begin
            if (!mismatch) begin
                stall_cnt <= '0;
            end else if (stall_cnt != TIMEOUT_C) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (mismatch && (stall_cnt >= TIMEOUT_C - 1'b1)) begin
                order_err <= 1'b1;
            end
            unexp_err <= sb_valid && empty;
        end
    end

endmodule : b_resp_order_queue

// File: tb/tb_b_resp_order_queue.sv
// ----------------------------------------------------------------------------
// tb_b_resp_order_queue
// Directed self-checking bench for b_resp_order_queue with default parameters
// (DEPTH=4, MID_W=1, TIMEOUT=64). Inputs change 2 time units after a rising
// edge; outputs are sampled 1 unit after the inputs settle.
// ----------------------------------------------------------------------------
module tb_b_resp_order_queue;
    import b_resp_order_queue_pkg::*;

    logic       ACLK = 1'b0;
    logic       ARESET;
    logic       push_valid;
    logic [0:0] push_mid;
    logic       push_ready;
    logic       sb_valid;
    logic [0:0] sb_id;
    logic [1:0] sb_resp;
    logic       sb_ready;
    logic       ob_valid;
    logic [0:0] ob_id;
    logic [1:0] ob_resp;
    logic       ob_ready;
    logic [2:0] occupancy;
    logic       order_err;
    logic       unexp_err;

    int total = 0;
    int bad   = 0;

    always #5 ACLK = ~ACLK;

    b_resp_order_queue dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .push_valid (push_valid),
        .push_mid   (push_mid),
        .push_ready (push_ready),
        .sb_valid   (sb_valid),
        .sb_id      (sb_id),
        .sb_resp    (sb_resp),
        .sb_ready   (sb_ready),
        .ob_valid   (ob_valid),
        .ob_id      (ob_id),
        .ob_resp    (ob_resp),
        .ob_ready   (ob_ready),
        .occupancy  (occupancy),
        .order_err  (order_err),
        .unexp_err  (unexp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then move away from it before driving.
    task automatic tick();
        @(posedge ACLK);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_sb(input logic v, input logic [0:0] id, input logic [1:0] resp);
        sb_valid = v;
        sb_id    = id;
        sb_resp  = resp;
    endtask

    task automatic check_ob(input string tag, input logic v, input logic [0:0] id,
                            input logic [1:0] resp, input logic [2:0] occ);
        check({tag, ".ob_valid"},  32'(ob_valid),  32'(v));
        check({tag, ".ob_id"},     32'(ob_id),     32'(id));
        check({tag, ".ob_resp"},   32'(ob_resp),   32'(resp));
        check({tag, ".occupancy"}, 32'(occupancy), 32'(occ));
    endtask

    task automatic check_reset_state(input string tag);
        check_ob(tag, 1'b0, 1'b0, BRESP_OKAY, 3'd0);
        check({tag, ".push_ready"}, 32'(push_ready), 32'd1);
        check({tag, ".sb_ready"},   32'(sb_ready),   32'd0);
        check({tag, ".order_err"},  32'(order_err),  32'd0);
        check({tag, ".unexp_err"},  32'(unexp_err),  32'd0);
    endtask

    initial begin
        ARESET     = 1'b1;
        push_valid = 1'b0;
        push_mid   = 1'b0;
        ob_ready   = 1'b0;
        drive_sb(1'b0, 1'b0, BRESP_OKAY);
        tick();
        tick();
        ARESET = 1'b0;
        settle();
        check_reset_state("reset");

        // ---- In-order release: push 0,1,0 then drain back-to-back ----------
        push_valid = 1'b1; push_mid = 1'b0; tick();
        push_mid = 1'b1; tick();
        push_mid = 1'b0; tick();
        push_valid = 1'b0;
        settle();
        check("fill3.occupancy", 32'(occupancy), 32'd3);
        ob_ready = 1'b1;
        drive_sb(1'b1, 1'b0, BRESP_OKAY);
        settle();
        check("ord.sb_ready0", 32'(sb_ready), 32'd1);
        tick();
        check_ob("ord.beat0", 1'b1, 1'b0, BRESP_OKAY, 3'd2);
        drive_sb(1'b1, 1'b1, BRESP_SLVERR);
        settle();
        check("ord.sb_ready1", 32'(sb_ready), 32'd1);
        tick();
        check_ob("ord.beat1", 1'b1, 1'b1, BRESP_SLVERR, 3'd1);
        drive_sb(1'b1, 1'b0, BRESP_OKAY);
        tick();
        check_ob("ord.beat2", 1'b1, 1'b0, BRESP_OKAY, 3'd0);
        drive_sb(1'b0, 1'b0, BRESP_OKAY);
        tick();
        settle();
        check("ord.drained", 32'(ob_valid), 32'd0);
        check("ord.unexp_err", 32'(unexp_err), 32'd0);

        // ---- Full queue: 5th push refused, then pop and push+pop -----------
        push_valid = 1'b1; push_mid = 1'b1; tick();
        push_mid = 1'b0; tick();
        push_mid = 1'b1; tick();
        push_mid = 1'b1; tick();
        push_mid = 1'b0;
        settle();
        check("full.occupancy", 32'(occupancy), 32'd4);
        check("full.push_ready", 32'(push_ready), 32'd0);
        tick();
        check("full.fifth_ignored", 32'(occupancy), 32'd4);
        // Push still offered while full, plus an accept: only the pop lands.
        drive_sb(1'b1, 1'b1, BRESP_EXOKAY);
        settle();
        check("full.sb_ready", 32'(sb_ready), 32'd1);
        tick();
        check_ob("full.pop", 1'b1, 1'b1, BRESP_EXOKAY, 3'd3);
        // Simultaneous push and pop at occupancy 3.
        drive_sb(1'b1, 1'b0, BRESP_OKAY);
        tick();
        check_ob("pushpop", 1'b1, 1'b0, BRESP_OKAY, 3'd3);
        push_valid = 1'b0;
        drive_sb(1'b1, 1'b1, BRESP_SLVERR);
        tick();
        check_ob("drain.a", 1'b1, 1'b1, BRESP_SLVERR, 3'd2);
        drive_sb(1'b1, 1'b1, BRESP_DECERR);
        tick();
        check_ob("drain.b", 1'b1, 1'b1, BRESP_DECERR, 3'd1);
        drive_sb(1'b1, 1'b0, BRESP_EXOKAY);
        tick();
        check_ob("drain.c", 1'b1, 1'b0, BRESP_EXOKAY, 3'd0);
        drive_sb(1'b0, 1'b0, BRESP_OKAY);
        tick();

        // ---- Mismatch timeout -----------------------------------------------
        push_valid = 1'b1; push_mid = 1'b0; tick();
        push_valid = 1'b0;
        drive_sb(1'b1, 1'b1, BRESP_OKAY);
        settle();
        check("stall.sb_ready_start", 32'(sb_ready), 32'd0);
        for (int i = 0; i < 63; i++) tick();
        check("stall.sb_ready_63", 32'(sb_ready), 32'd0);
        check("stall.order_err_63", 32'(order_err), 32'd0);
        tick();
        check("stall.order_err_64", 32'(order_err), 32'd1);
        check("stall.occupancy", 32'(occupancy), 32'd1);
        drive_sb(1'b1, 1'b0, BRESP_OKAY);
        settle();
        check("stall.match_ready", 32'(sb_ready), 32'd1);
        tick();
        check_ob("stall.accepted", 1'b1, 1'b0, BRESP_OKAY, 3'd0);
        check("stall.order_err_sticky", 32'(order_err), 32'd1);

        // ---- Unexpected responses on an empty queue ---------------------------
        drive_sb(1'b1, 1'b0, BRESP_OKAY);
        settle();
        check("unexp.sb_ready", 32'(sb_ready), 32'd0);
        check("unexp.lag", 32'(unexp_err), 32'd0);
        tick();
        check("unexp.c1", 32'(unexp_err), 32'd1);
        tick();
        check("unexp.c2", 32'(unexp_err), 32'd1);
        tick();
        drive_sb(1'b0, 1'b0, BRESP_OKAY);
        settle();
        check("unexp.c3", 32'(unexp_err), 32'd1);
        tick();
        check("unexp.cleared", 32'(unexp_err), 32'd0);

        // ---- Downstream backpressure -----------------------------------------
        push_valid = 1'b1; push_mid = 1'b0; tick();
        tick();
        push_valid = 1'b0;
        ob_ready = 1'b0;
        drive_sb(1'b1, 1'b0, BRESP_OKAY);
        tick();
        check_ob("bp.load", 1'b1, 1'b0, BRESP_OKAY, 3'd1);
        drive_sb(1'b1, 1'b0, BRESP_DECERR);
        settle();
        check("bp.sb_ready_blocked", 32'(sb_ready), 32'd0);
        tick();
        check_ob("bp.hold", 1'b1, 1'b0, BRESP_OKAY, 3'd1);
        ob_ready = 1'b1;
        settle();
        check("bp.sb_ready_free", 32'(sb_ready), 32'd1);
        tick();
        check_ob("bp.reload", 1'b1, 1'b0, BRESP_DECERR, 3'd0);
        drive_sb(1'b0, 1'b0, BRESP_OKAY);
        tick();
        check("bp.drained", 32'(ob_valid), 32'd0);

        // ---- Reset mid-operation ---------------------------------------------
        push_valid = 1'b1; push_mid = 1'b1; tick();
        push_mid = 1'b0; tick();
        push_mid = 1'b1; tick();
        push_mid = 1'b0; tick();
        push_valid = 1'b0;
        ob_ready = 1'b0;
        drive_sb(1'b1, 1'b1, BRESP_SLVERR);
        tick();
        check_ob("mid.before_reset", 1'b1, 1'b1, BRESP_SLVERR, 3'd3);
        drive_sb(1'b0, 1'b0, BRESP_OKAY);
        ARESET = 1'b1;
        tick();
        check_reset_state("mid.reset");
        ARESET = 1'b0;
        drive_sb(1'b1, 1'b0, BRESP_OKAY);
        settle();
        check("mid.entries_gone", 32'(sb_ready), 32'd0);
        drive_sb(1'b0, 1'b0, BRESP_OKAY);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_b_resp_order_queue
